piso_serializer_mc: RTL and testbench
=====================================

// Module: piso_serializer_mc
// PURPOSE
//  Parametrised multi-channel parallel-to-serial converter built in fabric logic, with one clock.
//  Accepts CHANNELS words of DATA_WIDTH bits per transfer through a valid/ready input and buffers them in a FIFO.
//  Shifts each word out one bit per clk on complementary output pairs dout_p/dout_n.
//  Inserts IDLE_WORD when the FIFO runs dry, so the serial stream never stalls.
//  Serves low-rate TMDS-style links and loopback test paths where no 5x clock is available.
// PARAMETERS
//  DATA_WIDTH  10              bits per word per channel; minimum 2
//  CHANNELS    3               number of independent serial lanes; minimum 1
//  FIFO_DEPTH  4               input FIFO entries; power of two, minimum 2
//  IDLE_WORD   10'b1101010100  per-lane word sent on underflow (DATA_WIDTH bits)
//  MSB_FIRST   0               0: bit 0 is sent first; 1: bit DATA_WIDTH-1 is sent first
// PORTS
//  clk          in   1                      single clock; all logic is on the rising edge
//  rst_n        in   1                      asynchronous, active-low reset
//  in_data      in   CHANNELS*DATA_WIDTH    lane k occupies [k*DATA_WIDTH +: DATA_WIDTH]
//  in_valid     in   1                      in_data is valid
//  in_ready     out  1                      FIFO can accept a transfer this cycle
//  enable       in   1                      run the serializer
//  dout_p       out  CHANNELS               serial data, true polarity
//  dout_n       out  CHANNELS               serial data, complement
//  word_strobe  out  1                      1-cycle pulse on every shifter load
//  underflow    out  1                      1-cycle pulse when a load takes IDLE_WORD
//  fifo_level   out  $clog2(FIFO_DEPTH)+1   current FIFO occupancy
// BEHAVIOUR
//  Reset values: dout_p=0, dout_n=all 1, in_ready=1, word_strobe=0, underflow=0, fifo_level=0.
//    Reset also sets state=IDLE and bit_cnt=0, and flushes the FIFO.
//  Reset asserted mid-word aborts the word immediately; no partial completion.
//  FIFO:
//    - push when in_valid&&in_ready; in_ready = (fifo_level != FIFO_DEPTH), derived from registered level.
//    - push and pop in the same cycle leave the level unchanged.
//    - pointers wrap modulo FIFO_DEPTH.
//  State IDLE:
//    - bit_cnt held at 0; no pops; dout_p/dout_n hold their last values.
//    - enable=1 -> RUN; the first RUN cycle is a load cycle.
//  State RUN:
//    - Load cycle (bit_cnt==0):
//        shreg <= FIFO head if non-empty (pop), else IDLE_WORD on every lane with underflow=1.
//        word_strobe=1; dout_p <= first bit of the loaded word.
//    - Other cycles: dout_p <= next bit of shreg; bit_cnt increments.
//    - bit_cnt wraps DATA_WIDTH-1 -> 0, so the next load is back-to-back with no gap bit.
//    - enable is sampled only when bit_cnt==DATA_WIDTH-1: enable=0 -> IDLE, so the current word always completes.
//  Timing:
//    - dout_n is always the bitwise complement of dout_p; both are registered and glitch-free.
//    - Latency: word pushed at cycle t into an empty FIFO with a RUN load at t+1 gives first bit on dout at t+2.
//    - Each word occupies exactly DATA_WIDTH consecutive clk cycles on dout.
//  Lanes are loaded and shifted in lockstep; a single bit_cnt is shared.
// STRUCTURE
//  serdes_pkg:
//    - TMDS control-token constants (CTRL_00..CTRL_11), used for IDLE_WORD.
//    - state_t enum {IDLE, RUN}.
//  Sub-module sync_fifo_fwft:
//    - first-word-fall-through FIFO, width CHANNELS*DATA_WIDTH, depth FIFO_DEPTH.
//    - exposes level, full and empty.
//  Top level holds the FSM, bit counter, per-lane shift registers and output registers.
// TESTING
//  1 Reset: hold rst_n=0 -> dout_p=0, dout_n=3'b111, in_ready=1, fifo_level=0; release -> outputs unchanged.
//  2 Single word: lane0=10'h2A5, enable=1.
//      -> dout_p[0] = 1,0,1,0,0,1,0,1,0,1 on 10 consecutive cycles; dout_n[0] is the complement.
//      -> then IDLE_WORD follows with an underflow pulse.
//  3 Underflow: enable=1 with the FIFO empty for 30 cycles.
//      -> IDLE_WORD repeated 3 times; underflow and word_strobe pulse at cycles 0, 10, 20.
//  4 Full: enable=0, push 5 words -> 4 accepted, in_ready=0 after the 4th, fifo_level=4, 5th word not stored.
//  5 Streaming with continuous in_valid: 8 words in order, no gap bits, word_strobe every 10 cycles.
//      Deassert enable at bit 3 of word 8 -> word 8 completes, then the block goes to IDLE.
//  6 Reset mid-word at bit 5 -> outputs go to reset values immediately.
//      Post-reset, the next load is the new FIFO head, not the remainder of the old word.
//      Rerun scenario 2 with MSB_FIRST=1 -> bit order reversed.

Source files
------------

// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared types and TMDS control tokens for the serializer
package serdes_pkg;

  // TMDS control-period tokens; CTRL_00 is the default idle word.
  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through synchronous FIFO
module sync_fifo_fwft #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally (depth is a power of two); level tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/piso_serializer_mc.sv
// rtl/piso_serializer_mc.sv - multi-lane parallel-to-serial converter with idle fill
module piso_serializer_mc
  import serdes_pkg::*;
#(
  parameter int                    DATA_WIDTH = 10,
  parameter int                    CHANNELS   = 3,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = CTRL_00,
  parameter bit                    MSB_FIRST  = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CHANNELS*DATA_WIDTH-1:0]   in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             enable,
  output logic [CHANNELS-1:0]              dout_p,
  output logic [CHANNELS-1:0]              dout_n,
  output logic                             word_strobe,
  output logic                             underflow,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level
);

  localparam int                WORD_W   = CHANNELS * DATA_WIDTH;
  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_t                                  state;
  state_t                                  state_nxt;
  logic [CNT_W-1:0]                        bit_cnt;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0]     shreg;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0]     shreg_nxt;
  logic [CHANNELS-1:0]                     dout_nxt;
  logic [DATA_WIDTH-1:0]                   lane_src;
  logic [WORD_W-1:0]                       fifo_head;
  logic [WORD_W-1:0]                       load_word;
  logic                                    fifo_full;
  logic                                    fifo_empty;
  logic                                    load;
  logic                                    last;
  logic                                    pop;

  assign in_ready  = !fifo_full;
  assign load      = (state == RUN) && (bit_cnt == '0);
  assign last      = (bit_cnt == LAST_BIT);
  assign pop       = load && !fifo_empty;
  assign load_word = fifo_empty ? {CHANNELS{IDLE_WORD}} : fifo_head;

  sync_fifo_fwft #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_valid && in_ready),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next state: enable is only honoured on the last bit so words never truncate.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (last && !enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-lane shift: load cycle takes the new word, other cycles consume shreg.
  always_comb begin
    shreg_nxt = shreg;
    dout_nxt  = dout_p;
    lane_src  = '0;
    if (state == RUN) begin
      for (int k = 0; k < CHANNELS; k++) begin
        lane_src     = load ? load_word[k*DATA_WIDTH +: DATA_WIDTH] : shreg[k];
        dout_nxt[k]  = MSB_FIRST ? lane_src[DATA_WIDTH-1] : lane_src[0];
        shreg_nxt[k] = MSB_FIRST ? (lane_src << 1) : (lane_src >> 1);
      end
    end
  end

  // State, counter, shifters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      dout_p      <= '0;
      dout_n      <= '1;
      word_strobe <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= ((state == RUN) && !last) ? bit_cnt + CNT_W'(1) : '0;
      shreg       <= shreg_nxt;
      dout_p      <= dout_nxt;
      dout_n      <= ~dout_nxt;
      word_strobe <= load;
      underflow   <= load && fifo_empty;
    end
  end

endmodule

// File: tb/tb_piso_serializer_mc.sv
// tb/tb_piso_serializer_mc.sv - directed self-checking bench for piso_serializer_mc
module tb_piso_serializer_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        enable;
  logic [2:0]  dout_p;
  logic [2:0]  dout_n;
  logic        word_strobe;
  logic        underflow;
  logic [2:0]  fifo_level;

  logic        m_in_ready;
  logic [2:0]  m_dout_p;
  logic [2:0]  m_dout_n;
  logic        m_word_strobe;
  logic        m_underflow;
  logic [2:0]  m_fifo_level;

  int          total = 0;
  int          bad   = 0;
  logic [29:0] wd [8];
  logic [29:0] idle30;
  logic [9:0]  w2a5;
  logic [2:0]  e;
  int          p;
  bit          track;

  always #5 clk = ~clk;

  piso_serializer_mc dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .enable      (enable),
    .dout_p      (dout_p),
    .dout_n      (dout_n),
    .word_strobe (word_strobe),
    .underflow   (underflow),
    .fifo_level  (fifo_level)
  );

  piso_serializer_mc #(.MSB_FIRST(1'b1)) dut_m (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (m_in_ready),
    .enable      (enable),
    .dout_p      (m_dout_p),
    .dout_n      (m_dout_n),
    .word_strobe (m_word_strobe),
    .underflow   (m_underflow),
    .fifo_level  (m_fifo_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; when tracking a stream, advance to the next word on acceptance.
  task automatic tick();
    logic acc;
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (track && acc) begin
      p++;
      if (p < 8) in_data = wd[p];
      else       in_valid = 1'b0;
    end
  endtask

  function automatic logic [2:0] lanes_bit(input logic [29:0] w, input int b, input bit msb);
    logic [2:0] r;
    for (int k = 0; k < 3; k++) r[k] = msb ? w[k*10 + 9 - b] : w[k*10 + b];
    return r;
  endfunction

  initial begin
    wd[0] = 30'h1234_5678; wd[1] = 30'h2AAA_5555; wd[2] = 30'h0003_FFFF; wd[3] = 30'h3FF0_0000;
    wd[4] = 30'h1357_9BDF; wd[5] = 30'h2468_ACE0; wd[6] = 30'h0F0F_0F0F; wd[7] = 30'h3C3C_3C3C;
    idle30 = {3{10'b1101010100}};
    w2a5   = 10'h2A5;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; enable = 1'b0; track = 1'b0; p = 0;

    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout_p", dout_p, 3'b000);
    chk("rst_dout_n", dout_n, 3'b111);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_strobe", word_strobe, 0);
    chk("rst_underflow", underflow, 0);
    rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_dout_p", dout_p, 3'b000);
    chk("post_rst_dout_n", dout_n, 3'b111);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_level", fifo_level, 0);

    // single word 0x2A5 on lane 0, both bit orders
    in_data = 30'h2A5; in_valid = 1'b1; enable = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("s2_level", fifo_level, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("s2_lsb_bit", dout_p[0], w2a5[i]);
      chk("s2_lsb_comp", dout_n[0], !w2a5[i]);
      chk("s2_msb_bit", m_dout_p[0], w2a5[9-i]);
      chk("s2_other_lanes", dout_p[2:1], 2'b00);
      chk("s2_strobe", word_strobe, (i == 0));
      chk("s2_underflow", underflow, 0);
    end

    // underflow: three idle words back to back
    for (int i = 0; i < 30; i++) begin
      tick();
      e = lanes_bit(idle30, i % 10, 1'b0);
      chk("s3_dout_p", dout_p, e);
      chk("s3_dout_n", dout_n, e ^ 3'b111);
      chk("s3_underflow", underflow, (i % 10 == 0));
      chk("s3_strobe", word_strobe, (i % 10 == 0));
    end
    enable = 1'b0;
    repeat (10) tick();
    chk("s3_tail_bit9", dout_p, 3'b111);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s3_idle_strobe", word_strobe, 0);
      chk("s3_idle_hold", dout_p, 3'b111);
    end

    // fill the FIFO while disabled; fifth word is refused
    track = 1'b1; p = 0; in_data = wd[0]; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s4_level", fifo_level, i + 1);
      chk("s4_in_ready", in_ready, (i < 3));
    end
    tick();
    chk("s4_full_level", fifo_level, 4);
    chk("s4_full_ready", in_ready, 0);

    // stream 8 words with in_valid held; drop enable at bit 3 of word 8
    enable = 1'b1;
    tick();
    for (int w = 0; w < 8; w++) begin
      for (int b = 0; b < 10; b++) begin
        tick();
        e = lanes_bit(wd[w], b, 1'b0);
        chk("s5_dout_p", dout_p, e);
        chk("s5_dout_n", dout_n, e ^ 3'b111);
        chk("s5_strobe", word_strobe, (b == 0));
        chk("s5_underflow", underflow, 0);
        if (w == 7 && b == 3) enable = 1'b0;
      end
    end
    e = lanes_bit(wd[7], 9, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s5_idle_strobe", word_strobe, 0);
      chk("s5_idle_hold", dout_p, e);
      chk("s5_idle_level", fifo_level, 0);
    end
    track = 1'b0;

    // reset mid-word, with a second word queued
    in_data = wd[5]; in_valid = 1'b1; enable = 1'b1;
    tick();
    in_data = wd[6];
    tick();
    in_valid = 1'b0;
    chk("s6_pushpop_level", fifo_level, 1);
    chk("s6_bit0", dout_p, lanes_bit(wd[5], 0, 1'b0));
    for (int i = 1; i < 6; i++) begin
      tick();
      chk("s6_bits", dout_p, lanes_bit(wd[5], i, 1'b0));
    end
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_dout_p", dout_p, 3'b000);
    chk("s6_rst_dout_n", dout_n, 3'b111);
    chk("s6_rst_level", fifo_level, 0);
    chk("s6_rst_ready", in_ready, 1);
    chk("s6_rst_strobe", word_strobe, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; enable = 1'b0;
    tick();
    in_data = wd[7]; in_valid = 1'b1; enable = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("s6_new_head", dout_p, lanes_bit(wd[7], i, 1'b0));
      if (i == 0) begin
        chk("s6_new_strobe", word_strobe, 1);
        chk("s6_new_underflow", underflow, 0);
      end
    end
    enable = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
